// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl_pkg
// Description : Shared encodings for the alarm-clock control block.
//               Holds the mode and alarm state encodings, the digit index map
//               and the bit positions of the buttons in the press vector.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

    // Operating mode, also presented on the mode output
    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_ADJ_TIME  = 2'd1,
        MODE_ADJ_ALARM = 2'd2
    } mode_t;

    // Alarm sounder state
    typedef enum logic [0:0] {
        AL_IDLE    = 1'b0,
        AL_RINGING = 1'b1
    } alarm_state_t;

    // Digit positions within a counter bank
    localparam int DIG_MIN_U = 0;
    localparam int DIG_MIN_T = 1;
    localparam int DIG_HR_U  = 2;
    localparam int DIG_HR_T  = 3;

    // Bit positions of the buttons in the press vector
    localparam int BTN_C   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_D   = 4;
    localparam int NUM_BTN = 5;

endpackage
`default_nettype wire

// File: rtl/clock_adjust_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_detect
// Description : Rising-edge detector for a vector of synchronised levels.
//               press is high for the cycle in which a level is high and its
//               registered previous value was low, so a held level yields a
//               single press.
// Ports       : clk    - system clock
//               rst    - asynchronous active-low reset
//               level  - WIDTH synchronised input levels
//               press  - WIDTH rising-edge indications (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= level;
        end
    end

    assign press = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/clock_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_adjust_ctrl
// Description : Alarm-clock control. Decodes the five buttons into the mode
//               FSM (clock / adjust time / adjust alarm), routes one-cycle
//               up/down pulses to the selected digit, gates the time counter
//               run enable, drives the digit blink and runs the alarm FSM.
// Ports       : clk, rst (async active-low)
//               btn_c/l/r/u/d   - debounced button levels
//               tick_1hz        - one-cycle pulse per second
//               alarm_match     - time equals alarm setting (level)
//               alarm_en        - alarm arm switch
//               run_en          - time counter enable
//               time_up/down    - per-digit pulses to the time bank
//               alarm_up/down   - per-digit pulses to the alarm bank
//               digit_sel       - one-hot selected digit
//               mode            - 0 clock, 1 adjust time, 2 adjust alarm
//               ringing, blink  - alarm sounding, selected-digit blink
// Revision    : 1.0 - initial release
// ============================================================================
module clock_adjust_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int RING_TIMEOUT = 60,
    parameter int TO_W         = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_c,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic                  btn_u,
    input  logic                  btn_d,
    input  logic                  tick_1hz,
    input  logic                  alarm_match,
    input  logic                  alarm_en,
    output logic                  run_en,
    output logic [NUM_DIGITS-1:0] time_up,
    output logic [NUM_DIGITS-1:0] time_down,
    output logic [NUM_DIGITS-1:0] alarm_up,
    output logic [NUM_DIGITS-1:0] alarm_down,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [1:0]            mode,
    output logic                  ringing,
    output logic                  blink
);

    localparam logic [NUM_DIGITS-1:0] c_sel_reset    = NUM_DIGITS'(1) << DIG_MIN_U;
    localparam logic [TO_W-1:0]       c_ring_timeout = TO_W'(RING_TIMEOUT);

    logic [NUM_BTN-1:0]    w_btn;
    logic [NUM_BTN-1:0]    w_press;
    logic                  w_match_rise;
    logic                  w_any_press;
    logic [TO_W-1:0]       w_cnt_inc;

    mode_t                 r_mode,      w_mode_nxt;
    alarm_state_t          r_al_state,  w_al_nxt;
    logic [NUM_DIGITS-1:0] r_digit_sel, w_sel_nxt;
    logic [NUM_DIGITS-1:0] r_time_up,   w_tu_nxt;
    logic [NUM_DIGITS-1:0] r_time_down, w_td_nxt;
    logic [NUM_DIGITS-1:0] r_alarm_up,  w_au_nxt;
    logic [NUM_DIGITS-1:0] r_alarm_dn,  w_ad_nxt;
    logic [TO_W-1:0]       r_to_cnt,    w_to_nxt;
    logic                  r_blink,     w_blink_nxt;
    logic                  r_run_en,    w_run_nxt;

    assign w_btn = {btn_d, btn_u, btn_r, btn_l, btn_c};

    btn_edge_detect #(.WIDTH(NUM_BTN)) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .level (w_btn),
        .press (w_press)
    );

    btn_edge_detect #(.WIDTH(1)) u_match_edge (
        .clk   (clk),
        .rst   (rst),
        .level (alarm_match),
        .press (w_match_rise)
    );

    assign w_any_press = |w_press;
    assign w_cnt_inc   = r_to_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= MODE_CLOCK;
            r_al_state  <= AL_IDLE;
            r_digit_sel <= c_sel_reset;
            r_time_up   <= '0;
            r_time_down <= '0;
            r_alarm_up  <= '0;
            r_alarm_dn  <= '0;
            r_to_cnt    <= '0;
            r_blink     <= 1'b0;
            r_run_en    <= 1'b1;
        end else begin
            r_mode      <= w_mode_nxt;
            r_al_state  <= w_al_nxt;
            r_digit_sel <= w_sel_nxt;
            r_time_up   <= w_tu_nxt;
            r_time_down <= w_td_nxt;
            r_alarm_up  <= w_au_nxt;
            r_alarm_dn  <= w_ad_nxt;
            r_to_cnt    <= w_to_nxt;
            r_blink     <= w_blink_nxt;
            r_run_en    <= w_run_nxt;
        end
    end

    always_comb begin
        w_mode_nxt  = r_mode;
        w_al_nxt    = r_al_state;
        w_sel_nxt   = r_digit_sel;
        w_to_nxt    = r_to_cnt;
        w_tu_nxt    = '0;
        w_td_nxt    = '0;
        w_au_nxt    = '0;
        w_ad_nxt    = '0;
        w_blink_nxt = r_blink;
        w_run_nxt   = r_run_en;

        if (r_al_state == AL_RINGING) begin
            // Any press only silences the alarm; it has no mode/digit effect
            if (w_any_press || !alarm_en) begin
                w_al_nxt = AL_IDLE;
            end else if (tick_1hz) begin
                w_to_nxt = w_cnt_inc;
                if (w_cnt_inc == c_ring_timeout) begin
                    w_al_nxt = AL_IDLE;
                end
            end
        end else begin
            if (w_match_rise && alarm_en && (r_mode == MODE_CLOCK)) begin
                w_al_nxt = AL_RINGING;
                w_to_nxt = '0;
            end

            if (w_press[BTN_C]) begin
                case (r_mode)
                    MODE_CLOCK:    w_mode_nxt = MODE_ADJ_TIME;
                    MODE_ADJ_TIME: w_mode_nxt = MODE_ADJ_ALARM;
                    default:       w_mode_nxt = MODE_CLOCK;
                endcase
                w_sel_nxt = c_sel_reset;
            end else if (r_mode != MODE_CLOCK) begin
                if (w_press[BTN_L]) begin
                    w_sel_nxt = {r_digit_sel[NUM_DIGITS-2:0], r_digit_sel[NUM_DIGITS-1]};
                end else if (w_press[BTN_R]) begin
                    w_sel_nxt = {r_digit_sel[0], r_digit_sel[NUM_DIGITS-1:1]};
                end

                // Simultaneous up and down cancel out
                if (w_press[BTN_U] != w_press[BTN_D]) begin
                    if (r_mode == MODE_ADJ_TIME) begin
                        if (w_press[BTN_U]) w_tu_nxt = r_digit_sel;
                        else                w_td_nxt = r_digit_sel;
                    end else begin
                        if (w_press[BTN_U]) w_au_nxt = r_digit_sel;
                        else                w_ad_nxt = r_digit_sel;
                    end
                end
            end
        end

        if ((w_mode_nxt == MODE_CLOCK) || (w_mode_nxt != r_mode)) begin
            w_blink_nxt = 1'b0;
        end else if (tick_1hz) begin
            w_blink_nxt = ~r_blink;
        end

        w_run_nxt = (w_mode_nxt != MODE_ADJ_TIME);
    end

    assign run_en     = r_run_en;
    assign time_up    = r_time_up;
    assign time_down  = r_time_down;
    assign alarm_up   = r_alarm_up;
    assign alarm_down = r_alarm_dn;
    assign digit_sel  = r_digit_sel;
    assign mode       = r_mode;
    assign ringing    = (r_al_state == AL_RINGING);
    assign blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_adjust_ctrl
// Description : Self-checking bench for clock_adjust_ctrl. Directed scenarios
//               followed by randomised button/tick/alarm traffic, all checked
//               every cycle against an integer-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_adjust_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_c, btn_l, btn_r, btn_u, btn_d;
    logic       tick_1hz, alarm_match, alarm_en;
    logic       run_en, ringing, blink;
    logic [3:0] time_up, time_down, alarm_up, alarm_down, digit_sel;
    logic [1:0] mode;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: mode as 0..2, selected digit as an index 0..3
    int         m_mode, m_idx, m_cnt;
    bit         m_ring, m_blink, m_mprev;
    bit   [4:0] m_prev;
    logic [3:0] m_tu, m_td, m_au, m_ad;

    clock_adjust_ctrl #(
        .NUM_DIGITS  (4),
        .RING_TIMEOUT(60),
        .TO_W        (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_c      (btn_c),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .tick_1hz   (tick_1hz),
        .alarm_match(alarm_match),
        .alarm_en   (alarm_en),
        .run_en     (run_en),
        .time_up    (time_up),
        .time_down  (time_down),
        .alarm_up   (alarm_up),
        .alarm_down (alarm_down),
        .digit_sel  (digit_sel),
        .mode       (mode),
        .ringing    (ringing),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode  = 0;
        m_idx   = 0;
        m_cnt   = 0;
        m_ring  = 0;
        m_blink = 0;
        m_mprev = 0;
        m_prev  = '0;
        m_tu = '0; m_td = '0; m_au = '0; m_ad = '0;
    endtask

    // Advance the model by one clock edge using the inputs sampled there
    task automatic model_step();
        bit [4:0]   lv, pr;
        bit         rise, changed;
        int         old_idx;
        logic [3:0] v;
        lv      = {btn_d, btn_u, btn_r, btn_l, btn_c};
        pr      = lv & ~m_prev;
        m_prev  = lv;
        rise    = alarm_match && !m_mprev;
        m_mprev = alarm_match;
        m_tu = '0; m_td = '0; m_au = '0; m_ad = '0;
        changed = 0;
        if (m_ring) begin
            if (pr != 0 || !alarm_en) m_ring = 0;
            else if (tick_1hz) begin
                m_cnt++;
                if (m_cnt >= 60) m_ring = 0;
            end
        end else begin
            if (rise && alarm_en && m_mode == 0) begin
                m_ring = 1;
                m_cnt  = 0;
            end
            if (pr[0]) begin
                m_mode  = (m_mode + 1) % 3;
                m_idx   = 0;
                changed = 1;
            end else if (m_mode != 0) begin
                old_idx = m_idx;
                if (pr[1])      m_idx = (m_idx + 1) % 4;
                else if (pr[2]) m_idx = (m_idx + 3) % 4;
                v = 4'(1 << old_idx);
                if (pr[3] != pr[4]) begin
                    if (m_mode == 1) begin
                        if (pr[3]) m_tu = v; else m_td = v;
                    end else begin
                        if (pr[3]) m_au = v; else m_ad = v;
                    end
                end
            end
        end
        if (m_mode == 0 || changed) m_blink = 0;
        else if (tick_1hz)          m_blink = !m_blink;
    endtask

    task automatic check_all();
        chk("mode",       32'(mode),       32'(m_mode));
        chk("digit_sel",  32'(digit_sel),  32'(1) << m_idx);
        chk("run_en",     32'(run_en),     32'(m_mode != 1));
        chk("ringing",    32'(ringing),    32'(m_ring));
        chk("blink",      32'(blink),      32'(m_blink));
        chk("time_up",    32'(time_up),    32'(m_tu));
        chk("time_down",  32'(time_down),  32'(m_td));
        chk("alarm_up",   32'(alarm_up),   32'(m_au));
        chk("alarm_down", 32'(alarm_down), 32'(m_ad));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Assert reset between edges, check the immediate effect, release later
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        check_all();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        btn_c = 0; btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
        tick_1hz = 0; alarm_match = 0; alarm_en = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Held centre button: exactly one mode step
        btn_c = 1;
        repeat (10) cycle();
        btn_c = 0;
        cycle();
        chk("hold_c_mode", 32'(mode), 32'd1);
        chk("hold_c_run_en", 32'(run_en), 32'd0);

        // Left rotation around all four digits, then one right
        for (int i = 0; i < 4; i++) begin
            btn_l = 1; cycle();
            btn_l = 0; cycle();
        end
        chk("rot_l_wrap", 32'(digit_sel), 32'h1);
        btn_r = 1; cycle();
        btn_r = 0; cycle();
        chk("rot_r_wrap", 32'(digit_sel), 32'h8);

        // To adjust-alarm, select digit 2, adjust
        btn_c = 1; cycle(); btn_c = 0; cycle();
        repeat (2) begin
            btn_l = 1; cycle();
            btn_l = 0; cycle();
        end
        btn_u = 1; cycle();
        chk("alarm_up_pulse", 32'(alarm_up), 32'h4);
        chk("time_up_quiet", 32'(time_up), 32'h0);
        btn_u = 0; cycle();
        chk("alarm_up_single", 32'(alarm_up), 32'h0);
        btn_u = 1; btn_d = 1; cycle();
        btn_u = 0; btn_d = 0; cycle();
        btn_d = 1; cycle(); btn_d = 0; cycle();
        repeat (3) begin tick_1hz = 1; cycle(); tick_1hz = 0; cycle(); end

        // Back to clock, alarm rings and times out
        btn_c = 1; cycle(); btn_c = 0; cycle();
        alarm_en = 1; alarm_match = 1; cycle();
        chk("ring_start", 32'(ringing), 32'd1);
        for (int i = 0; i < 60; i++) begin
            tick_1hz = 1; cycle();
            tick_1hz = 0; cycle();
        end
        chk("ring_timeout", 32'(ringing), 32'd0);
        repeat (5) cycle();

        // Ringing silenced by a button press
        alarm_match = 0; cycle();
        alarm_match = 1; cycle();
        btn_c = 1; cycle(); btn_c = 0; cycle();
        chk("ring_press_mode", 32'(mode), 32'd0);
        chk("ring_press_off", 32'(ringing), 32'd0);

        // Ringing stopped by disarming
        alarm_match = 0; cycle();
        alarm_match = 1; cycle();
        alarm_en = 0; cycle();
        chk("ring_disarm", 32'(ringing), 32'd0);
        alarm_en = 1;

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            int b;
            b = $urandom_range(0, 9);
            btn_c = (b == 4); btn_l = (b == 5); btn_r = (b == 6);
            btn_u = (b == 7 || b == 9); btn_d = (b == 8 || b == 9);
            tick_1hz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) alarm_match = ~alarm_match;
            if ($urandom_range(0, 63) == 0) alarm_en = ~alarm_en;
            cycle();
            if (i == 700) async_reset();
        end

        // Async reset in adjust-alarm with blink high
        btn_c = 0; btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0;
        tick_1hz = 0; alarm_match = 0; alarm_en = 0;
        cycle();
        async_reset();
        btn_c = 1; cycle(); btn_c = 0; cycle();
        btn_c = 1; cycle(); btn_c = 0; cycle();
        tick_1hz = 1; cycle(); tick_1hz = 0; cycle();
        chk("pre_reset_blink", 32'(blink), 32'd1);
        chk("pre_reset_mode", 32'(mode), 32'd2);
        async_reset();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_adjust_ctrl.md
Name: clock_adjust_ctrl

Overview:
- Control block for the alarm clock. Sequences the four time-digit modulo counters and the four alarm-digit modulo counters.
- Decodes the five user buttons into a mode FSM: run clock, adjust time, adjust alarm.
- Routes single-cycle count_up/count_down pulses to the selected digit and gates the run enable of the time counters.
- Runs the alarm ringing FSM.
- Sits between the debounced button inputs and the counter chain / alarm comparator.

Parameters:
- NUM_DIGITS, 4, number of digit counters per bank; index 0 = minutes units, 3 = hours tens.
- RING_TIMEOUT, 60, number of tick_1hz pulses after which ringing self-terminates.
- TO_W, 6, width of the ring timeout counter; must hold RING_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_c  in  1  centre button; synchronized and debounced level
- btn_l  in  1  left button level
- btn_r  in  1  right button level
- btn_u  in  1  up button level
- btn_d  in  1  down button level
- tick_1hz  in  1  one-cycle pulse, once per second
- alarm_match  in  1  level; high while time equals alarm setting
- alarm_en  in  1  alarm arm switch
- run_en  out  1  enable for time counters
- time_up  out  NUM_DIGITS  one-cycle increment pulse per time digit
- time_down  out  NUM_DIGITS  one-cycle decrement pulse per time digit
- alarm_up  out  NUM_DIGITS  one-cycle increment pulse per alarm digit
- alarm_down  out  NUM_DIGITS  one-cycle decrement pulse per alarm digit
- digit_sel  out  NUM_DIGITS  one-hot selected digit
- mode  out  2  0=CLOCK, 1=ADJ_TIME, 2=ADJ_ALARM
- ringing  out  1  alarm sounding
- blink  out  1  display blink for the selected digit

Behaviour:
- Reset (rst low, asynchronous) values:
  - mode=CLOCK, digit_sel=0001, run_en=1, ringing=0, blink=0.
  - All up/down pulse outputs 0; timeout counter 0.
  - Button and alarm_match history registers 0.
- Press detection:
  - press_x = btn_x & ~btn_x_prev, with prev registered each cycle. A held button yields exactly one press.
  - All outputs are registered. A pulse output is high for exactly the one cycle following the clock edge at which the press is sampled. Latency is 1 cycle; a pulse never lasts more than 1 cycle.
- Press priority within a cycle:
  - Ringing consumes all presses.
  - Otherwise C beats L/R/U/D.
  - L beats R.
  - U together with D produces no pulse.
- Mode FSM:
  - CLOCK -C-> ADJ_TIME -C-> ADJ_ALARM -C-> CLOCK.
  - Every mode change sets digit_sel=0001.
  - U/D/L/R have no effect in CLOCK.
- Digit select (ADJ modes only):
  - L rotates digit_sel toward the higher index; 1000 wraps to 0001.
  - R rotates toward the lower index; 0001 wraps to 1000.
- Adjust pulses:
  - ADJ_TIME: U gives time_up = digit_sel; D gives time_down = digit_sel.
  - ADJ_ALARM: U/D drive alarm_up/alarm_down the same way.
  - The other bank stays 0.
- run_en:
  - 0 while mode=ADJ_TIME, 1 in CLOCK and ADJ_ALARM.
  - Updates in the same cycle as the mode register.
- blink:
  - Toggles on each tick_1hz while mode≠CLOCK.
  - Forced to 0 in CLOCK and on every mode change.
- Alarm FSM, states IDLE and RINGING:
  - IDLE -> RINGING on a rising edge of alarm_match while alarm_en=1 and mode=CLOCK. The timeout counter clears on entry.
  - While RINGING, each tick_1hz increments the counter.
  - RINGING -> IDLE on any press of any button (the press is consumed; no mode or digit action), on alarm_en=0, or when the counter reaches RING_TIMEOUT.
  - ringing=1 exactly while in RINGING.
  - A level alarm_match that stays high does not retrigger.
  - An alarm_match edge while RINGING is ignored.
- Reset asserted mid-operation returns all state to the reset values immediately, including a ringing alarm.

Decomposition:
- Shared package clock_ctrl_pkg holds:
  - mode encoding constants: MODE_CLOCK, MODE_ADJ_TIME, MODE_ADJ_ALARM;
  - alarm state constants: AL_IDLE, AL_RINGING;
  - digit index constants: DIG_MIN_U, DIG_MIN_T, DIG_HR_U, DIG_HR_T.
- One sub-module, btn_edge_detect:
  - parameterized width;
  - registers the prev levels and emits the press vector;
  - instantiated once for the five buttons. alarm_match gets its own 1-bit instance.

Test Plan:
- Reset, then btn_c held 10 cycles -> mode=1 for good, run_en=0 from the cycle after the edge, exactly one mode step.
- In ADJ_TIME: btn_l pressed 4 times -> digit_sel 0010, 0100, 1000, 0001; then btn_r once -> 1000.
- ADJ_ALARM, digit_sel=0100, btn_u pulse -> alarm_up=0100 for exactly 1 cycle, time_up stays 0000. btn_u and btn_d in the same cycle -> all pulses 0.
- CLOCK, alarm_en=1, alarm_match rises and stays high -> ringing=1 next cycle. After 60 tick_1hz, ringing=0 with no retrigger while alarm_match stays high.
- Ringing, btn_c press -> ringing=0, mode stays CLOCK. Ringing then alarm_en=0 -> ringing=0 next cycle.
- rst driven low asynchronously mid-ADJ_ALARM with blink=1 -> immediate mode=0, digit_sel=0001, blink=0, run_en=1.
